// File: rtl/serial_pkg.sv
// Shared definitions for the serial word transmitter and the sequence detector it feeds.
package serial_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

endpackage

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: one-word holding register feeding an MSB-first
// shift register, gap-free across back-to-back words.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic             dout,
    output logic             dvalid,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wready_d, dout_d, dvalid_d, busy_d;

    // Next-state and next-output logic; outputs are precomputed so they can be registered.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;

        // Accept only into an empty holding register, so it never collides with a drain.
        if (wvalid && !hold_full_q) begin
            hold_d      = wdata;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    sreg_d      = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    sreg_d = sreg_q << 1;
                    cnt_d  = CW'(cnt_q + 1'b1);
                end else if (hold_full_q) begin
                    sreg_d      = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        dvalid_d = (state_d == SHIFT);
        dout_d   = dvalid_d && sreg_d[WIDTH-1];
        wready_d = !hold_full_d;
        busy_d   = dvalid_d || hold_full_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            wready      <= 1'b1;
            dout        <= 1'b0;
            dvalid      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            wready      <= wready_d;
            dout        <= dout_d;
            dvalid      <= dvalid_d;
            busy        <= busy_d;
        end
    end

endmodule
